cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Conditional-execution stage placed directly downstream of the instruction decoder in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field of the current instruction against the stored flags.
- Gates the decoder's PCS/RegW/MemW/FlagW requests into the final PCSrc, RegWrite and MemWrite strobes and the flag-register write enables.

Parameters:
- FLAG_RESET, 4'b0000, value loaded into {N,Z,C,V} on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Cond  input  4  condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  input  2  decoder flag-write request; [1] selects N,Z and [0] selects C,V.
- PCS  input  1  decoder PC-write request (branch or write to R15).
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- Stall  input  1  holds the instruction; suppresses all side effects.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register-file write.
- MemWrite  output  1  gated data-memory write.
- CondEx  output  1  condition-pass indication for the current instruction.
- Flags  output  4  current registered {N,Z,C,V}.

Behaviour:
- Reset (asynchronous, active-high): Flags <= FLAG_RESET immediately, without waiting for a clock edge. The outputs are combinational and follow from the reset flag value. With the default FLAG_RESET and Cond=1110 they are CondEx=1, PCSrc=PCS, RegWrite=RegW, MemWrite=MemW.
- Flag register state: two independently enabled groups, NZ = Flags[3:2] and CV = Flags[1:0].
- Condition evaluation is combinational on the registered Flags only, never on ALUFlags. An instruction therefore sees the flags left by earlier instructions, not its own ALU result.
- CondEx by Cond value:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111: 0 (unsupported; the instruction is squashed)
- Gated outputs, all combinational (zero latency):
  - Let ex = CondEx & !Stall.
  - PCSrc = PCS & ex
  - RegWrite = RegW & ex
  - MemWrite = MemW & ex
  - FlagWrite[1:0] = FlagW & {2{ex}} (internal)
- Flag update on the rising edge of clk:
  - If FlagWrite[1]: Flags[3:2] <= ALUFlags[3:2].
  - If FlagWrite[0]: Flags[1:0] <= ALUFlags[1:0].
  - Disabled groups hold their value.
- Simultaneous events:
  - FlagW=11 with a failing condition: no flag update.
  - FlagW=10 (logical op with S): only NZ is updated; C and V are retained.
- Stall=1: all gated outputs are 0 and Flags hold, regardless of Cond or FlagW. CondEx still reports the raw evaluation.
- Reset asserted mid-instruction: flags are forced to FLAG_RESET immediately. Any flag write pending on that edge is lost. Reset has priority over FlagWrite.
- X on the decoder inputs while PCS/RegW/MemW/FlagW are all 0 must not corrupt Flags.

Test Plan:
- Reset, then Cond=1110, RegW=1, MemW=0, PCS=0 -> Flags=0000, CondEx=1, RegWrite=1, MemWrite=0, PCSrc=0.
- CMP result ALUFlags=0110 with FlagW=11, Cond=1110; next cycle Cond=0000 (EQ), PCS=1 -> Flags=0110, CondEx=1, PCSrc=1. Then Cond=0001 (NE) -> PCSrc=0.
- Flags=0110, ALUFlags=1000, FlagW=10 (ANDS) -> Flags=1010 (C retained). Then Cond=1011 (LT) -> CondEx=1.
- Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, RegW=1 -> CondEx=0, RegWrite=0, Flags stay 0000 after the edge.
- Stall=1 with Cond=1110, FlagW=11, MemW=1, ALUFlags=0101 -> MemWrite=0, Flags unchanged. Release Stall -> MemWrite=1, Flags=0101 after the edge.
- Assert reset asynchronously between edges with Flags=1111 -> Flags=0000 before the next clk edge. Cond=1111 at any time -> CondEx=0 and all gated outputs 0.

Source files
------------

// File: rtl/cond_logic.sv
// cond_logic
// ----------
// Conditional-execution stage that sits right after the instruction decoder
// in the single-cycle ARM datapath. It owns the architectural NZCV flag
// register and evaluates the current instruction's condition field against
// the stored flags. The decoder's side-effect requests are then gated into
// the final write strobes.
//
// Ports:
//   clk       - system clock, flags update on the rising edge
//   reset     - asynchronous, active-high; loads FLAG_RESET into the flags
//   Cond      - condition field Instr[31:28]
//   ALUFlags  - {N,Z,C,V} produced by the ALU this cycle
//   FlagW     - flag-write request, [1] = N,Z group, [0] = C,V group
//   PCS       - PC-write request from the decoder
//   RegW      - register-write request from the decoder
//   MemW      - memory-write request from the decoder
//   Stall     - holds the instruction and suppresses every side effect
//   PCSrc     - gated PC write
//   RegWrite  - gated register-file write
//   MemWrite  - gated data-memory write
//   CondEx    - raw condition-pass result for the current instruction
//   Flags     - registered {N,Z,C,V}

module cond_logic #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic       flagN;
    logic       flagZ;
    logic       flagC;
    logic       flagV;
    logic       execEnable;
    logic [1:0] flagWrite;

    assign {flagN, flagZ, flagC, flagV} = Flags;

    // Condition evaluation looks only at the registered flags, so an
    // instruction sees the flags left behind by earlier instructions and
    // never its own ALU result. Code 1111 is unsupported and always fails,
    // which squashes the instruction.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = flagZ;
            4'b0001: CondEx = ~flagZ;
            4'b0010: CondEx = flagC;
            4'b0011: CondEx = ~flagC;
            4'b0100: CondEx = flagN;
            4'b0101: CondEx = ~flagN;
            4'b0110: CondEx = flagV;
            4'b0111: CondEx = ~flagV;
            4'b1000: CondEx = flagC & ~flagZ;
            4'b1001: CondEx = ~flagC | flagZ;
            4'b1010: CondEx = (flagN == flagV);
            4'b1011: CondEx = (flagN != flagV);
            4'b1100: CondEx = ~flagZ & (flagN == flagV);
            4'b1101: CondEx = flagZ | (flagN != flagV);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    // A stalled instruction still reports its raw condition result on
    // CondEx, but none of its side effects are allowed through.
    assign execEnable = CondEx & ~Stall;
    assign PCSrc      = PCS  & execEnable;
    assign RegWrite   = RegW & execEnable;
    assign MemWrite   = MemW & execEnable;
    assign flagWrite  = FlagW & {2{execEnable}};

    // The NZ and CV halves are enabled independently so that logical ops
    // with S can refresh N and Z while keeping the last carry/overflow.
    // Reset wins over any pending write on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags <= FLAG_RESET;
        end else begin
            if (flagWrite[1]) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (flagWrite[0]) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic
// -------------
// Self-checking bench for cond_logic: a directed vector table, hand-written
// reset sequences and a randomized run against a behavioural flag model.

module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    int passCount;
    int totalCount;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flagW;
        logic       pcs;
        logic       regW;
        logic       memW;
        logic       stall;
        logic       expCondEx;
        logic       expPcSrc;
        logic       expRegWrite;
        logic       expMemWrite;
        logic [3:0] expFlags;
    } vec_t;

    vec_t vecs[12];

    logic [3:0] modelFlags;

    cond_logic #(.FLAG_RESET(4'b0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .Stall    (Stall),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction's worth of decoder inputs.
    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] a,
                                 input logic [1:0] fw, input logic p,
                                 input logic r, input logic m, input logic s);
        Cond     = c;
        ALUFlags = a;
        FlagW    = fw;
        PCS      = p;
        RegW     = r;
        MemW     = m;
        Stall    = s;
    endtask

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference condition rule: the even codes name a base test, the odd
    // code right after it is its complement. AL's complement is the
    // unsupported 1111, which therefore never passes.
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    initial begin
        passCount  = 0;
        totalCount = 0;

        // Directed table: each row is one cycle starting from the flags left
        // by the row before it.
        //          cond   alu    fw    pcs   regW  memW  stall condEx pcSrc regWr memWr flags
        vecs[0]  = '{4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[1]  = '{4'hE, 4'h6, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[2]  = '{4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110};
        vecs[3]  = '{4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[4]  = '{4'hE, 4'h8, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010};
        vecs[5]  = '{4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010};
        vecs[6]  = '{4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[7]  = '{4'h0, 4'hF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[8]  = '{4'hE, 4'h5, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[9]  = '{4'hE, 4'h5, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0101};
        vecs[10] = '{4'hF, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101};
        vecs[11] = '{4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111};

        // Reset state, checked while reset is still held.
        reset = 1'b1;
        applyStimulus(4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("reset Flags", Flags, 4'b0000);
        checkOutput("reset CondEx", {3'b0, CondEx}, 4'd1);
        checkOutput("reset RegWrite", {3'b0, RegWrite}, 4'd1);
        checkOutput("reset MemWrite", {3'b0, MemWrite}, 4'd0);
        checkOutput("reset PCSrc", {3'b0, PCSrc}, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].cond, vecs[i].alu, vecs[i].flagW, vecs[i].pcs,
                          vecs[i].regW, vecs[i].memW, vecs[i].stall);
            #1;
            checkOutput($sformatf("vec%0d CondEx", i), {3'b0, CondEx}, {3'b0, vecs[i].expCondEx});
            checkOutput($sformatf("vec%0d PCSrc", i), {3'b0, PCSrc}, {3'b0, vecs[i].expPcSrc});
            checkOutput($sformatf("vec%0d RegWrite", i), {3'b0, RegWrite}, {3'b0, vecs[i].expRegWrite});
            checkOutput($sformatf("vec%0d MemWrite", i), {3'b0, MemWrite}, {3'b0, vecs[i].expMemWrite});
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d Flags", i), Flags, vecs[i].expFlags);
            @(negedge clk);
        end

        // Asynchronous reset between edges with Flags=1111.
        applyStimulus(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset Flags", Flags, 4'b0000);

        // Reset held across an edge beats a pending flag write.
        applyStimulus(4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset priority Flags", Flags, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        // Garbage on Cond/ALUFlags with no write requests leaves Flags alone.
        applyStimulus(4'hE, 4'h9, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("load 1001", Flags, 4'b1001);
        @(negedge clk);
        applyStimulus(4'bxxxx, 4'bxxxx, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("x inputs hold Flags", Flags, 4'b1001);
        @(negedge clk);

        // Randomized run against the behavioural model.
        modelFlags = 4'b1001;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic ex;
            logic pulseReset;
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) == 0));
            pulseReset = ($urandom_range(0, 24) == 0);
            #1;
            ex = refCond(Cond, modelFlags) && !Stall;
            checkOutput("rand CondEx", {3'b0, CondEx}, {3'b0, refCond(Cond, modelFlags)});
            checkOutput("rand PCSrc", {3'b0, PCSrc}, {3'b0, PCS && ex});
            checkOutput("rand RegWrite", {3'b0, RegWrite}, {3'b0, RegW && ex});
            checkOutput("rand MemWrite", {3'b0, MemWrite}, {3'b0, MemW && ex});
            if (pulseReset) begin
                reset = 1'b1;
                #1;
                modelFlags = 4'b0000;
                checkOutput("rand async reset", Flags, modelFlags);
                reset = 1'b0;
                ex = refCond(Cond, modelFlags) && !Stall;
            end
            @(posedge clk);
            if (ex && FlagW[1]) modelFlags[3:2] = ALUFlags[3:2];
            if (ex && FlagW[0]) modelFlags[1:0] = ALUFlags[1:0];
            #1;
            checkOutput("rand Flags", Flags, modelFlags);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
